icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter SETS, default 16, number of direct-mapped one-word entries (power of two, 2..64).
REQ-002: CLK  input  1  single clock, all state on rising edge.
REQ-003: RST  input  1  asynchronous, active-high reset.
REQ-004: imemREN  input  1  datapath instruction read request.
REQ-005: imemaddr  input  32  datapath byte address; bits [1:0] ignored.
REQ-006: ihit  output  1  imemload valid for imemaddr this cycle.
REQ-007: imemload  output  32  instruction word returned to datapath.
REQ-008: iREN  output  1  memory read request.
REQ-009: iaddr  output  32  memory word address, bits [1:0] = 0.
REQ-010: iwait  input  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0.
REQ-011: iload  input  32  memory read data.

Function
REQ-012: Address split: offset [1:0], index [log2(SETS)+1:2], tag = remaining upper bits; each entry holds valid, tag, 32-bit data.
REQ-013: FSM states IDLE and FILL; reset state IDLE.
REQ-014: IDLE hit (imemREN=1, valid[index]=1, tag match) SHALL give ihit=1 and imemload=data[index] combinationally in the same cycle; zero-cycle hit latency.
REQ-015: IDLE miss (imemREN=1, no hit) SHALL latch {imemaddr[31:2],2'b00} as the fill address and go to FILL next edge; ihit=0.
REQ-016: IDLE with imemREN=0 SHALL keep ihit=0, iREN=0, no state change.
REQ-017: FILL SHALL drive iREN=1 and iaddr=latched fill address every cycle; ihit=0.
REQ-018: FILL with iwait=1 SHALL hold state.
REQ-019: FILL with iwait=0 SHALL write iload, fill tag, valid=1 into the fill index on that edge and return to IDLE; the repeated request then hits the next cycle (miss penalty = memory latency + 1 cycle).
REQ-020: Changes to imemaddr or imemREN during FILL SHALL NOT alter the fill; the latched address completes.
REQ-021: A fill to an index holding a different tag SHALL overwrite it (no replacement choice).
REQ-022: In IDLE iREN=0 and iaddr=0.
REQ-023: imemload SHALL be 0 whenever ihit=0.
REQ-024: The cache never writes memory; no dirty state exists.

Reset
REQ-025: RST=1 SHALL immediately clear all valid bits, force IDLE, and drive ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-026: RST asserted mid-FILL SHALL abort the fill with no entry written; after release, the request misses again.
REQ-027: Data and tag arrays need not be reset; only valid bits and FSM/latched-address state are reset.

Configuration
REQ-028: Macro ICACHE_STATS_EN, when defined, SHALL add outputs hit_count (32) and miss_count (32), reset to 0, incrementing once per IDLE cycle with a hit and once per IDLE->FILL transition respectively, saturating at 32'hFFFFFFFF.
REQ-029: Without ICACHE_STATS_EN those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-030: Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, memory iwait=1 for 3 cycles then iload=0x2001_0005 -> iREN=1, iaddr=0x40 for 4 cycles, then ihit=1, imemload=0x2001_0005 the following cycle.
REQ-031: Hit: repeat imemaddr=0x0000_0042 after REQ-030 fill -> ihit=1 same cycle, imemload=0x2001_0005, iREN=0.
REQ-032: Conflict: with SETS=16 fill 0x0000_0040 then request 0x0000_0080 (same index 0) -> miss, fill, then 0x40 misses again.
REQ-033: Address change mid-fill: miss on 0x100, switch imemaddr to 0x200 while iwait=1 -> iaddr stays 0x100; after fill 0x200 misses, 0x100 hits.
REQ-034: Reset mid-fill: assert RST during FILL with iwait=1 -> iREN=0 immediately; after release, 0x100 misses and refills.
REQ-035: With ICACHE_STATS_EN, sequence miss, hit, hit on 0x40 -> miss_count=1, hit_count=2.

Source files
------------

// File: rtl/icache_if.sv
// Datapath and memory-side signals of the instruction cache.
// The cache uses the slave view; whatever drives requests and memory uses the master view.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped one-word icache: zero-cycle hit; a miss stalls for memory latency + 1 while iwait holds FILL.
// Defining ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q;
  logic [29:0]       fill_word_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              miss;
  logic              fill_done;
  logic              unused_offset;

  assign req_idx       = bus.imemaddr[IDX_W+1:2];
  assign req_tag       = bus.imemaddr[31:IDX_W+2];
  assign fill_idx      = fill_word_q[IDX_W-1:0];
  assign fill_tag      = fill_word_q[29:IDX_W];
  assign unused_offset = ^bus.imemaddr[1:0];

  assign hit       = (state_q == IDLE) && bus.imemREN && valid_q[req_idx]
                     && (tag_q[req_idx] == req_tag);
  assign miss      = (state_q == IDLE) && bus.imemREN && !hit;
  assign fill_done = (state_q == FILL) && !bus.iwait;

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[req_idx] : '0;
  assign bus.iREN     = (state_q == FILL);
  assign bus.iaddr    = (state_q == FILL) ? {fill_word_q, 2'b00} : '0;

  // The fill address is captured once at the miss; later request changes are ignored until IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      fill_word_q <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            fill_word_q <= bus.imemaddr[31:2];
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (!bus.iwait) begin
            valid_q[fill_idx] <= 1'b1;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data storage is unreset; valid_q alone decides whether an entry is usable.
  always_ff @(posedge CLK) begin
    if (fill_done && !RST) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand sequences for mid-fill corners, and a randomized run against a word-address cache model.
module tb_icache;
  localparam int SETS = 16;

  logic CLK;
  logic RST;
  icache_if bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.SETS(SETS)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: each set remembers which word address it holds.
  bit          ref_v    [SETS];
  logic [29:0] ref_word [SETS];

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vt [7];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0040) return 32'h2001_0005;
    return {~w[15:0], w[15:0]};
  endfunction

  function automatic int set_of(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    return int'(w) % SETS;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = set_of(a);
    return ref_v[s] && (ref_word[s] == a[31:2]);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) ref_v[s] = 1'b0;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    bus.imemREN = 1'b0;
    bus.iwait = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_clear();
  endtask

  // Request in an IDLE cycle; checks the combinational response before the next edge.
  task automatic probe(input string nm, input logic [31:0] a, input bit eh, input logic [31:0] ed);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    @(negedge CLK);
    chk({nm, ".ihit"}, {31'b0, bus.ihit}, {31'b0, eh});
    chk({nm, ".imemload"}, bus.imemload, eh ? ed : 32'h0);
    chk({nm, ".iREN"}, {31'b0, bus.iREN}, 32'h0);
    chk({nm, ".iaddr"}, bus.iaddr, 32'h0);
  endtask

  // Follows a missed probe: lat busy cycles, then one data cycle.
  task automatic fill(input string nm, input logic [31:0] a, input int lat, input logic [31:0] data,
                      input bit alt_en, input logic [31:0] alt);
    @(posedge CLK);
    #1;
    for (int c = 0; c <= lat; c++) begin
      if (alt_en) bus.imemaddr = alt;
      bus.iwait = (c < lat);
      bus.iload = (c < lat) ? $urandom : data;
      @(negedge CLK);
      chk({nm, ".fill_iREN"}, {31'b0, bus.iREN}, 32'h1);
      chk({nm, ".fill_iaddr"}, bus.iaddr, {a[31:2], 2'b00});
      chk({nm, ".fill_ihit"}, {31'b0, bus.ihit}, 32'h0);
      chk({nm, ".fill_imemload"}, bus.imemload, 32'h0);
      @(posedge CLK);
      #1;
    end
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
  endtask

  task automatic access(input string nm, input logic [31:0] a, input int lat, input bit eh,
                        input logic [31:0] data);
    probe(nm, a, eh, data);
    if (!eh) begin
      fill(nm, a, lat, data, 1'b0, 32'h0);
      probe({nm, ".refetch"}, a, 1'b1, data);
    end
    @(posedge CLK);
    #1;
    ref_v[set_of(a)]    = 1'b1;
    ref_word[set_of(a)] = a[31:2];
  endtask

  initial begin
    vt[0] = '{32'h0000_0040, 3, 1'b0, 32'h2001_0005};
    vt[1] = '{32'h0000_0042, 0, 1'b1, 32'h2001_0005};
    vt[2] = '{32'h0000_0080, 2, 1'b0, 32'hFF7F_0080};
    vt[3] = '{32'h0000_0040, 1, 1'b0, 32'h2001_0005};
    vt[4] = '{32'h0000_0044, 0, 1'b0, 32'hFFBB_0044};
    vt[5] = '{32'h0000_0040, 0, 1'b1, 32'h2001_0005};
    vt[6] = '{32'h0000_0047, 0, 1'b1, 32'hFFBB_0044};

    RST = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;
    #2;
    chk("rst.ihit", {31'b0, bus.ihit}, 32'h0);
    chk("rst.imemload", bus.imemload, 32'h0);
    chk("rst.iREN", {31'b0, bus.iREN}, 32'h0);
    chk("rst.iaddr", bus.iaddr, 32'h0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      access($sformatf("vec%0d", i), vt[i].addr, vt[i].lat, vt[i].exp_hit, vt[i].exp_data);
    end

    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0040;
    @(negedge CLK);
    chk("noreq.ihit", {31'b0, bus.ihit}, 32'h0);
    chk("noreq.imemload", bus.imemload, 32'h0);
    @(negedge CLK);
    chk("noreq.iREN", {31'b0, bus.iREN}, 32'h0);
    @(posedge CLK);
    #1;

    // Address moves away mid-fill: the original address must still be fetched.
    probe("chg.miss", 32'h0000_0100, 1'b0, 32'h0);
    fill("chg", 32'h0000_0100, 2, mem_word(32'h0000_0100), 1'b1, 32'h0000_0200);
    probe("chg.alt", 32'h0000_0200, 1'b0, 32'h0);
    bus.imemaddr = 32'h0000_0100;
    #1;
    chk("chg.orig_ihit", {31'b0, bus.ihit}, 32'h1);
    chk("chg.orig_imemload", bus.imemload, mem_word(32'h0000_0100));
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;

    // Reset during a fill aborts it and leaves nothing written.
    do_reset();
    probe("rfill.miss", 32'h0000_0100, 1'b0, 32'h0);
    @(posedge CLK);
    #1 bus.iwait = 1'b1;
    @(negedge CLK);
    chk("rfill.iREN_before", {31'b0, bus.iREN}, 32'h1);
    #1 RST = 1'b1;
    #1;
    chk("rfill.iREN", {31'b0, bus.iREN}, 32'h0);
    chk("rfill.iaddr", bus.iaddr, 32'h0);
    chk("rfill.ihit", {31'b0, bus.ihit}, 32'h0);
    chk("rfill.imemload", bus.imemload, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0;
    model_clear();
    access("rfill.again", 32'h0000_0100, 1, 1'b0, mem_word(32'h0000_0100));

`ifdef ICACHE_STATS_EN
    do_reset();
    @(negedge CLK);
    chk("stats.rst_hit", hit_count, 32'd0);
    chk("stats.rst_miss", miss_count, 32'd0);
    @(posedge CLK);
    #1;
    access("stats.a", 32'h0000_0040, 1, 1'b0, mem_word(32'h0000_0040));
    access("stats.b", 32'h0000_0040, 0, 1'b1, mem_word(32'h0000_0040));
    bus.imemREN = 1'b0;
    @(negedge CLK);
    chk("stats.miss_count", miss_count, 32'd1);
    chk("stats.hit_count", hit_count, 32'd2);
    @(posedge CLK);
    #1;
`endif

    do_reset();
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        bus.imemREN  = 1'b0;
        bus.imemaddr = a;
        @(negedge CLK);
        chk("rnd.idle_ihit", {31'b0, bus.ihit}, 32'h0);
        chk("rnd.idle_imemload", bus.imemload, 32'h0);
        chk("rnd.idle_iREN", {31'b0, bus.iREN}, 32'h0);
        chk("rnd.idle_iaddr", bus.iaddr, 32'h0);
        @(posedge CLK);
        #1;
      end else begin
        access($sformatf("rnd%0d", n), a, int'($urandom_range(0, 3)), model_hit(a), mem_word(a));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
